// File: rtl/l1_flush_sequencer.sv
// L1 maintenance sequencer: round-robin arbitration of flush/clear requests, D-cache phase then
// I-cache clear, then a one-cycle ack. Optional per-phase watchdog under L1_FLUSH_TIMEOUT_EN.
module l1_flush_sequencer #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic [NREQ-1:0] req_flush,
  input  logic [NREQ-1:0] req_clear,
  output logic [NREQ-1:0] req_ack,
  output logic            busy,
  output logic            dcache_flush,
  output logic            dcache_clear,
  input  logic            dcache_flush_done,
  input  logic            dcache_clear_done,
  output logic            icache_clear,
  input  logic            icache_clear_done,
  output logic            timeout_err
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StDOp, StIOp, StAck} state_e;
  typedef enum logic {OpClear, OpFlush} op_e;

  if (NREQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("l1_flush_sequencer: NREQ and TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   pending;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   cand;
  logic              gnt_valid;
  logic              in_phase;
  logic              phase_done;
  logic              d_done;
  logic              timeout_hit;

  assign pending = req_flush | req_clear;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NREQ);
      if (!gnt_valid && pending[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Only the done matching the latched op is honoured.
  assign d_done     = (op_q == OpFlush) ? dcache_flush_done : dcache_clear_done;
  assign in_phase   = (state_q == StDOp) || (state_q == StIOp);
  assign phase_done = ((state_q == StDOp) && d_done) || ((state_q == StIOp) && icache_clear_done);

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (gnt_valid) state_d = StDOp;
      StDOp: begin
        if (d_done) state_d = StIOp;
        else if (timeout_hit) state_d = StAck;
      end
      StIOp: begin
        if (icache_clear_done) state_d = StAck;
        else if (timeout_hit) state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode, purely from registered state
  always_comb begin
    busy         = (state_q != StIdle);
    dcache_flush = (state_q == StDOp) && (op_q == OpFlush);
    dcache_clear = (state_q == StDOp) && (op_q == OpClear);
    icache_clear = (state_q == StIOp);
    req_ack      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ack[i] = (state_q == StAck) && (grant_q == IdxW'(i));
    end
  end

  // Grant, op and round-robin pointer latch on leaving IDLE.
  always_comb begin
    grant_d  = grant_q;
    op_d     = op_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle && gnt_valid) begin
      grant_d  = gnt_idx;
      op_d     = req_flush[gnt_idx] ? OpFlush : OpClear;
      rr_ptr_d = IdxW'((32'(gnt_idx) + 32'd1) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      grant_q  <= '0;
      op_q     <= OpClear;
      rr_ptr_q <= '0;
    end else begin
      grant_q  <= grant_d;
      op_q     <= op_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef L1_FLUSH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Fires in the TIMEOUT_CYCLES-th cycle of a phase; a matching done in that cycle wins.
  assign timeout_hit = in_phase && !phase_done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_phase) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1_flush_sequencer.sv
// Directed bench for l1_flush_sequencer (NREQ=2, TIMEOUT_CYCLES=8); the timeout scenario
// follows L1_FLUSH_TIMEOUT_EN.
module tb_l1_flush_sequencer;

  logic       clk;
  logic       nRST;
  logic [1:0] req_flush;
  logic [1:0] req_clear;
  logic [1:0] req_ack;
  logic       busy;
  logic       dcache_flush;
  logic       dcache_clear;
  logic       dcache_flush_done;
  logic       dcache_clear_done;
  logic       icache_clear;
  logic       icache_clear_done;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  l1_flush_sequencer #(
    .NREQ          (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .nRST             (nRST),
    .req_flush        (req_flush),
    .req_clear        (req_clear),
    .req_ack          (req_ack),
    .busy             (busy),
    .dcache_flush     (dcache_flush),
    .dcache_clear     (dcache_clear),
    .dcache_flush_done(dcache_flush_done),
    .dcache_clear_done(dcache_clear_done),
    .icache_clear     (icache_clear),
    .icache_clear_done(icache_clear_done),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_flush         = 2'b00;
    req_clear         = 2'b00;
    dcache_flush_done = 1'b0;
    dcache_clear_done = 1'b0;
    icache_clear_done = 1'b0;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_ack"}, req_ack, 2'b00);
    check_eq({tag, "_dflush"}, dcache_flush, 1'b0);
    check_eq({tag, "_dclear"}, dcache_clear, 1'b0);
    check_eq({tag, "_iclear"}, icache_clear, 1'b0);
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    apply_reset();
    check_idle("rst");
    check_eq("rst_terr", timeout_err, 1'b0);

    // Single flush, four-cycle dones on each phase.
    req_flush = 2'b01;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_eq("t1_dflush", dcache_flush, c <= 4);
      check_eq("t1_dclear", dcache_clear, 1'b0);
      check_eq("t1_iclear", icache_clear, (c >= 5) && (c <= 8));
      check_eq("t1_ack", req_ack, (c == 9) ? 2'b01 : 2'b00);
      check_eq("t1_busy", busy, 1'b1);
      dcache_flush_done = (c == 4);
      icache_clear_done = (c == 8);
      if (c == 9) req_flush = 2'b00;
    end
    tick();
    check_idle("t1_end");

    // Clear-only on requester 1; a flush_done during D_OP must be ignored.
    req_clear = 2'b10;
    tick();
    check_eq("t2_dclear_c1", dcache_clear, 1'b1);
    check_eq("t2_dflush_c1", dcache_flush, 1'b0);
    dcache_flush_done = 1'b1;
    tick();
    check_eq("t2_dclear_c2", dcache_clear, 1'b1);
    check_eq("t2_iclear_c2", icache_clear, 1'b0);
    dcache_flush_done = 1'b0;
    dcache_clear_done = 1'b1;
    tick();
    check_eq("t2_iclear_c3", icache_clear, 1'b1);
    check_eq("t2_dclear_c3", dcache_clear, 1'b0);
    dcache_clear_done = 1'b0;
    icache_clear_done = 1'b1;
    tick();
    check_eq("t2_ack", req_ack, 2'b10);
    icache_clear_done = 1'b0;
    req_clear = 2'b00;
    tick();
    check_idle("t2_end");

    // Round-robin from reset with zero-wait dones: acks alternate 0,1,0,1.
    apply_reset();
    req_flush = 2'b11;
    dcache_flush_done = 1'b1;
    icache_clear_done = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check_eq("t3_ack", req_ack,
               (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      if (c == 16) req_flush = 2'b00;
    end
    tick();
    check_idle("t3_end");

    // Flush and clear together on requester 0 -> flush path only.
    req_flush = 2'b01;
    req_clear = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_eq("t4_dclear", dcache_clear, 1'b0);
      check_eq("t4_dflush", dcache_flush, c == 1);
      check_eq("t4_ack", req_ack, (c == 3) ? 2'b01 : 2'b00);
      if (c == 3) begin
        req_flush = 2'b00;
        req_clear = 2'b00;
      end
    end
    tick();
    check_idle("t4_end");
    clear_inputs();

    // Reset during I_OP; after release requester 0 must win again.
    req_flush = 2'b01;
    tick();
    check_eq("t5_dflush", dcache_flush, 1'b1);
    dcache_flush_done = 1'b1;
    tick();
    check_eq("t5_iclear", icache_clear, 1'b1);
    dcache_flush_done = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    check_idle("t5_async");
    req_flush = 2'b11;
    dcache_flush_done = 1'b1;
    icache_clear_done = 1'b1;
    #1;
    nRST = 1'b1;
    tick();
    check_eq("t5_regrant_dflush", dcache_flush, 1'b1);
    tick();
    tick();
    check_eq("t5_regrant_ack", req_ack, 2'b01);
    clear_inputs();
    tick();
    check_idle("t5_end");

    // Missing D-cache done.
    check_eq("t6_terr_pre", timeout_err, 1'b0);
    req_clear = 2'b01;
`ifdef L1_FLUSH_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_eq("t6_dclear", dcache_clear, c <= 8);
      check_eq("t6_ack", req_ack, (c == 9) ? 2'b01 : 2'b00);
      check_eq("t6_terr", timeout_err, c == 9);
      if (c == 9) req_clear = 2'b00;
    end
    repeat (4) tick();
    check_eq("t6_busy_after", busy, 1'b0);
    check_eq("t6_terr_sticky", timeout_err, 1'b1);
    apply_reset();
    check_eq("t6_terr_cleared", timeout_err, 1'b0);
`else
    begin
      int acks_seen;
      acks_seen = 0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (req_ack != 2'b00) acks_seen++;
      end
      check_eq("t6_busy_hang", busy, 1'b1);
      check_eq("t6_dclear_held", dcache_clear, 1'b1);
      check_eq("t6_no_ack", acks_seen, 0);
      check_eq("t6_terr_tied", timeout_err, 1'b0);
    end
    apply_reset();
`endif
    check_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_flush_sequencer.md
# l1_flush_sequencer

Sequences L1 maintenance for the core: arbitrates flush and clear requests from NREQ requesters (fence.i logic, CSR/debug unit, ...) and drives the clear/flush handshakes of the D-cache and I-cache wrappers in a fixed order. The D-cache operation always completes before the I-cache clear, so a fence.i-style flush sees written-back data. Sits between the requesting pipeline/CSR logic and the cache-side clear/flush ports of both L1 wrappers.

## Interface
- NREQ, 2: number of requesters (≥1).
- TIMEOUT_CYCLES, 1024: watchdog limit per cache phase (used only with L1_FLUSH_TIMEOUT_EN).
- clk  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req_flush  in  NREQ  per-requester writeback+invalidate request (level, held until ack).
- req_clear  in  NREQ  per-requester invalidate-only request (level, held until ack).
- req_ack  out  NREQ  one-cycle completion pulse to granted requester.
- busy  out  1  high in any state other than IDLE.
- dcache_flush  out  1  flush request to D-cache wrapper.
- dcache_clear  out  1  clear request to D-cache wrapper.
- dcache_flush_done  in  1  D-cache flush complete.
- dcache_clear_done  in  1  D-cache clear complete.
- icache_clear  out  1  clear request to I-cache wrapper.
- icache_clear_done  in  1  I-cache clear complete.
- timeout_err  out  1  sticky watchdog error (tied 0 without L1_FLUSH_TIMEOUT_EN).

## Operation
- States: IDLE, D_OP, I_OP, ACK. All outputs Moore-decoded from registered state/grant.
- IDLE: pending[i] = req_flush[i] | req_clear[i]. If any pending, grant round-robin starting at rr_ptr; latch grant index and op = FLUSH if req_flush[grant] else CLEAR (flush is a superset; both set -> FLUSH). Go D_OP. rr_ptr <= (grant+1) mod NREQ.
- D_OP: dcache_flush=1 if op FLUSH, else dcache_clear=1. Exactly one asserted. Only the matching done is honoured (flush_done for FLUSH, clear_done for CLEAR); other done ignored. On matching done -> I_OP.
- I_OP: icache_clear=1 (I-cache holds no dirty data; clear for both ops). On icache_clear_done -> ACK.
- ACK: req_ack[grant]=1 for exactly one cycle -> IDLE.
- Requester contract: drop req on the clock edge that samples req_ack=1; a req still high in the following IDLE cycle is treated as a new request.
- Requests arriving while busy wait; no queueing beyond the level inputs.
- Reset (any time, incl. mid-op): state=IDLE, rr_ptr=0, grant=0, timeout counter=0, timeout_err=0; all outputs 0 immediately (asynchronously). Cache wrappers must tolerate request withdrawal.

## Timing
- Reset values: req_ack=0, busy=0, dcache_flush=0, dcache_clear=0, icache_clear=0, timeout_err=0.
- Cycle 0: request sampled in IDLE. Cycle 1: D_OP, cache request high. Done sampled high in cycle k≥1 -> cache request drops at cycle k+1 with I_OP active.
- Minimum request-to-ack: 3 cycles (done asserted in first cycle of each phase). Ack lasts 1 cycle; next grant possible 1 cycle after ACK (IDLE sampling cycle).
- Done high in the same cycle the phase is entered is accepted.
- Cache requests are level-held for the whole phase, never pulsed.

## Configuration
- L1_FLUSH_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES+1)) zeroed on entry to D_OP and I_OP, increments each cycle in those states. Reaching TIMEOUT_CYCLES without matching done -> force ACK (requester still acked), set timeout_err=1 (sticky until nRST). Done and limit in same cycle: done wins, no error.
- Not defined: no counter; controller waits indefinitely for done; timeout_err tied 0.

## Test plan
- Single flush: NREQ=2, req_flush[0]=1, done after 4 cycles each -> dcache_flush high cycles 1-4, icache_clear high 5-8, req_ack=2'b01 at cycle 9 only.
- Clear-only with wrong done: req_clear[1]=1, pulse dcache_flush_done during D_OP -> ignored; dcache_clear_done accepted; req_ack=2'b10 after I_OP.
- Round-robin: both requesters hold req_flush from reset, zero-wait dones -> acks order 0,1,0,1; each ack 3 cycles after its grant.
- Simultaneous flush+clear on requester 0 -> dcache_flush only (dcache_clear never high), single ack.
- Reset mid-op: nRST low during I_OP -> icache_clear, busy drop without clock edge; after release, held req re-granted starting from requester 0.
- Timeout (macro on, TIMEOUT_CYCLES=8): no dcache done -> ACK after 8 cycles in D_OP, timeout_err=1 and stays 1 until reset; macro off -> busy stays 1.
